// File: rtl/tlb_pkg.sv
// Shared encodings, field widths and CP0 register bit positions for the TLB
// instruction unit.
package tlb_pkg;

    // TLB instruction encodings carried on op_code
    typedef enum logic [1:0] {
        OP_TLBP  = 2'd0,
        OP_TLBR  = 2'd1,
        OP_TLBWI = 2'd2,
        OP_TLBWR = 2'd3
    } tlb_op_e;

    // CP0 register selects shared by the mtc0 write port and the read port
    typedef enum logic [2:0] {
        SEL_INDEX    = 3'd0,
        SEL_ENTRYLO0 = 3'd1,
        SEL_ENTRYLO1 = 3'd2,
        SEL_ENTRYHI  = 3'd3,
        SEL_WIRED    = 3'd4,
        SEL_RANDOM   = 3'd5
    } cp0_sel_e;

    localparam int unsigned VPN2_W = 19;
    localparam int unsigned ASID_W = 8;
    localparam int unsigned PFN_W  = 20;
    localparam int unsigned C_W    = 3;

    // EntryHi layout
    localparam int unsigned EHI_VPN2_LSB = 13;
    localparam int unsigned EHI_ASID_LSB = 0;

    // EntryLo layout
    localparam int unsigned LO_PFN_LSB = 6;
    localparam int unsigned LO_C_LSB   = 3;
    localparam int unsigned LO_D_BIT   = 2;
    localparam int unsigned LO_V_BIT   = 1;
    localparam int unsigned LO_G_BIT   = 0;

    // Index layout
    localparam int unsigned INDEX_P_BIT = 31;

    typedef struct packed {
        logic [PFN_W-1:0] pfn;
        logic [C_W-1:0]   c;
        logic             d;
        logic             v;
        logic             g;
    } entrylo_t;

    function automatic logic [31:0] pack_entrylo(input entrylo_t lo);
        logic [31:0] r;
        r = '0;
        r[LO_PFN_LSB +: PFN_W] = lo.pfn;
        r[LO_C_LSB +: C_W]     = lo.c;
        r[LO_D_BIT]            = lo.d;
        r[LO_V_BIT]            = lo.v;
        r[LO_G_BIT]            = lo.g;
        return r;
    endfunction

    function automatic entrylo_t unpack_entrylo(input logic [31:0] w);
        entrylo_t lo;
        lo.pfn = w[LO_PFN_LSB +: PFN_W];
        lo.c   = w[LO_C_LSB +: C_W];
        lo.d   = w[LO_D_BIT];
        lo.v   = w[LO_V_BIT];
        lo.g   = w[LO_G_BIT];
        return lo;
    endfunction

endpackage

// File: rtl/tlb_random.sv
// Wired register and the free-running Random replacement counter.
module tlb_random #(
    parameter  int unsigned TLBNUM = 16,
    localparam int unsigned IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wired_we_i,
    input  logic [IW-1:0] wired_wdata_i,
    output logic [IW-1:0] wired_o,
    output logic [IW-1:0] random_o
);

    localparam logic [IW-1:0] RAND_TOP = IW'(TLBNUM - 1);

    logic [IW-1:0] wired_q, wired_d;
    logic [IW-1:0] random_q, random_d;

    // Random counts down each cycle and wraps to the top at or below Wired
    always_comb begin
        wired_d  = wired_q;
        random_d = random_q;
        if (wired_we_i) begin
            wired_d  = wired_wdata_i;
            random_d = RAND_TOP;
        end else if (random_q <= wired_q) begin
            random_d = RAND_TOP;
        end else begin
            random_d = random_q - 1'b1;
        end
    end

    // Wired/Random state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wired_q  <= '0;
            random_q <= RAND_TOP;
        end else begin
            wired_q  <= wired_d;
            random_q <= random_d;
        end
    end

    assign wired_o  = wired_q;
    assign random_o = random_q;

endmodule

// File: rtl/tlb_op_unit.sv
// TLB instruction unit: CP0 TLB registers, TLBP/TLBR/TLBWI/TLBWR sequencing
// and the drive of the TLB search, read and write ports.
module tlb_op_unit
    import tlb_pkg::*;
#(
    parameter  int unsigned TLBNUM = 16,
    localparam int unsigned IW     = $clog2(TLBNUM)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              op_valid,
    input  logic [1:0]        op_code,
    output logic              op_ready,
    output logic              op_done,

    input  logic              mtc0_we,
    input  logic [2:0]        mtc0_sel,
    input  logic [31:0]       mtc0_wdata,

    input  logic [2:0]        rd_sel,
    output logic [31:0]       rd_data,

    output logic [VPN2_W-1:0] s_vpn2,
    output logic [ASID_W-1:0] s_asid,
    input  logic              s_found,
    input  logic [IW-1:0]     s_index,

    output logic              we,
    output logic [IW-1:0]     w_index,
    output logic [VPN2_W-1:0] w_vpn2,
    output logic [ASID_W-1:0] w_asid,
    output logic              w_g,
    output logic [PFN_W-1:0]  w_pfn0,
    output logic [C_W-1:0]    w_c0,
    output logic              w_d0,
    output logic              w_v0,
    output logic [PFN_W-1:0]  w_pfn1,
    output logic [C_W-1:0]    w_c1,
    output logic              w_d1,
    output logic              w_v1,

    output logic [IW-1:0]     r_index,
    input  logic [VPN2_W-1:0] r_vpn2,
    input  logic [ASID_W-1:0] r_asid,
    input  logic              r_g,
    input  logic [PFN_W-1:0]  r_pfn0,
    input  logic [C_W-1:0]    r_c0,
    input  logic              r_d0,
    input  logic              r_v0,
    input  logic [PFN_W-1:0]  r_pfn1,
    input  logic [C_W-1:0]    r_c1,
    input  logic              r_d1,
    input  logic              r_v1
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    tlb_op_e           op_q, op_d;

    logic [VPN2_W-1:0] ehi_vpn2_q, ehi_vpn2_d;
    logic [ASID_W-1:0] ehi_asid_q, ehi_asid_d;
    entrylo_t          lo0_q, lo0_d;
    entrylo_t          lo1_q, lo1_d;
    logic              idx_p_q, idx_p_d;
    logic [IW-1:0]     idx_q, idx_d;

    logic [IW-1:0]     wired;
    logic [IW-1:0]     random;
    logic              mtc0_fire;
    logic              wired_we;
    logic              exec_write;

    assign op_ready  = (state_q == S_IDLE);
    assign mtc0_fire = mtc0_we && op_ready;
    assign wired_we  = mtc0_fire && (mtc0_sel == SEL_WIRED);

    tlb_random #(
        .TLBNUM (TLBNUM)
    ) u_random (
        .clk           (clk),
        .rst           (rst),
        .wired_we_i    (wired_we),
        .wired_wdata_i (mtc0_wdata[IW-1:0]),
        .wired_o       (wired),
        .random_o      (random)
    );

    // FSM next state; the op is latched on acceptance
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    state_d = S_EXEC;
                    op_d    = tlb_op_e'(op_code);
                end
            end
            S_EXEC:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state and latched op registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_TLBP;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // CP0 register next state: software writes in IDLE, op results in EXEC
    always_comb begin
        ehi_vpn2_d = ehi_vpn2_q;
        ehi_asid_d = ehi_asid_q;
        lo0_d      = lo0_q;
        lo1_d      = lo1_q;
        idx_p_d    = idx_p_q;
        idx_d      = idx_q;

        if (mtc0_fire) begin
            case (cp0_sel_e'(mtc0_sel))
                SEL_INDEX:    idx_d = mtc0_wdata[IW-1:0];
                SEL_ENTRYLO0: lo0_d = unpack_entrylo(mtc0_wdata);
                SEL_ENTRYLO1: lo1_d = unpack_entrylo(mtc0_wdata);
                SEL_ENTRYHI: begin
                    ehi_vpn2_d = mtc0_wdata[EHI_VPN2_LSB +: VPN2_W];
                    ehi_asid_d = mtc0_wdata[EHI_ASID_LSB +: ASID_W];
                end
                default: ;
            endcase
        end

        if (state_q == S_EXEC) begin
            case (op_q)
                OP_TLBP: begin
                    if (s_found) begin
                        idx_p_d = 1'b0;
                        idx_d   = s_index;
                    end else begin
                        idx_p_d = 1'b1;
                    end
                end
                OP_TLBR: begin
                    ehi_vpn2_d = r_vpn2;
                    ehi_asid_d = r_asid;
                    lo0_d      = '{pfn: r_pfn0, c: r_c0, d: r_d0, v: r_v0, g: r_g};
                    lo1_d      = '{pfn: r_pfn1, c: r_c1, d: r_d1, v: r_v1, g: r_g};
                end
                default: ;
            endcase
        end
    end

    // CP0 register state
    always_ff @(posedge clk) begin
        if (rst) begin
            ehi_vpn2_q <= '0;
            ehi_asid_q <= '0;
            lo0_q      <= '0;
            lo1_q      <= '0;
            idx_p_q    <= 1'b0;
            idx_q      <= '0;
        end else begin
            ehi_vpn2_q <= ehi_vpn2_d;
            ehi_asid_q <= ehi_asid_d;
            lo0_q      <= lo0_d;
            lo1_q      <= lo1_d;
            idx_p_q    <= idx_p_d;
            idx_q      <= idx_d;
        end
    end

    // Register read mux, registered values only
    always_comb begin
        rd_data = '0;
        case (cp0_sel_e'(rd_sel))
            SEL_INDEX: begin
                rd_data[INDEX_P_BIT] = idx_p_q;
                rd_data[IW-1:0]      = idx_q;
            end
            SEL_ENTRYLO0: rd_data = pack_entrylo(lo0_q);
            SEL_ENTRYLO1: rd_data = pack_entrylo(lo1_q);
            SEL_ENTRYHI: begin
                rd_data[EHI_VPN2_LSB +: VPN2_W] = ehi_vpn2_q;
                rd_data[EHI_ASID_LSB +: ASID_W] = ehi_asid_q;
            end
            SEL_WIRED:  rd_data[IW-1:0] = wired;
            SEL_RANDOM: rd_data[IW-1:0] = random;
            default: ;
        endcase
    end

    // A reset arriving in EXEC/DONE suppresses the pulses of that same cycle
    assign exec_write = (state_q == S_EXEC) && ((op_q == OP_TLBWI) || (op_q == OP_TLBWR));
    assign we         = exec_write && !rst;
    assign op_done    = (state_q == S_DONE) && !rst;

    assign s_vpn2  = ehi_vpn2_q;
    assign s_asid  = ehi_asid_q;
    assign r_index = idx_q;

    assign w_index = (op_q == OP_TLBWR) ? random : idx_q;
    assign w_vpn2  = ehi_vpn2_q;
    assign w_asid  = ehi_asid_q;
    assign w_g     = lo0_q.g & lo1_q.g;
    assign w_pfn0  = lo0_q.pfn;
    assign w_c0    = lo0_q.c;
    assign w_d0    = lo0_q.d;
    assign w_v0    = lo0_q.v;
    assign w_pfn1  = lo1_q.pfn;
    assign w_c1    = lo1_q.c;
    assign w_d1    = lo1_q.d;
    assign w_v1    = lo1_q.v;

endmodule

// File: tb/tb_tlb_op_unit.sv
// Directed bench for tlb_op_unit with hand-computed expectations.
module tb_tlb_op_unit;
    import tlb_pkg::*;

    localparam int unsigned TLBNUM = 16;
    localparam int unsigned IW     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              op_valid;
    logic [1:0]        op_code;
    logic              op_ready;
    logic              op_done;
    logic              mtc0_we;
    logic [2:0]        mtc0_sel;
    logic [31:0]       mtc0_wdata;
    logic [2:0]        rd_sel;
    logic [31:0]       rd_data;
    logic [18:0]       s_vpn2;
    logic [7:0]        s_asid;
    logic              s_found;
    logic [IW-1:0]     s_index;
    logic              we;
    logic [IW-1:0]     w_index;
    logic [18:0]       w_vpn2;
    logic [7:0]        w_asid;
    logic              w_g;
    logic [19:0]       w_pfn0;
    logic [2:0]        w_c0;
    logic              w_d0;
    logic              w_v0;
    logic [19:0]       w_pfn1;
    logic [2:0]        w_c1;
    logic              w_d1;
    logic              w_v1;
    logic [IW-1:0]     r_index;
    logic [18:0]       r_vpn2;
    logic [7:0]        r_asid;
    logic              r_g;
    logic [19:0]       r_pfn0;
    logic [2:0]        r_c0;
    logic              r_d0;
    logic              r_v0;
    logic [19:0]       r_pfn1;
    logic [2:0]        r_c1;
    logic              r_d1;
    logic              r_v1;

    int errors = 0;
    int checks = 0;

    tlb_op_unit #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready), .op_done(op_done),
        .mtc0_we(mtc0_we), .mtc0_sel(mtc0_sel), .mtc0_wdata(mtc0_wdata),
        .rd_sel(rd_sel), .rd_data(rd_data),
        .s_vpn2(s_vpn2), .s_asid(s_asid), .s_found(s_found), .s_index(s_index),
        .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [2:0] sel);
        rd_sel = sel;
        #1;
    endtask

    task automatic mtc0(input logic [2:0] sel, input logic [31:0] d);
        mtc0_we    = 1'b1;
        mtc0_sel   = sel;
        mtc0_wdata = d;
        tick();
        mtc0_we    = 1'b0;
    endtask

    // Presents an op for one edge; returns in the EXEC cycle
    task automatic start_op(input logic [1:0] code);
        op_valid = 1'b1;
        op_code  = code;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        peek(SEL_RANDOM);
        checks++; if (rd_data !== 32'd15) begin errors++; $display("FAIL reset_random got=%h want=%h", rd_data, 32'd15); end
        checks++; if (op_ready !== 1'b1 || op_done !== 1'b0 || we !== 1'b0) begin errors++; $display("FAIL reset_ctrl got ready=%b done=%b we=%b want 1 0 0", op_ready, op_done, we); end
        peek(SEL_INDEX);
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_index got=%h want=0", rd_data); end
        peek(SEL_ENTRYHI);
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_entryhi got=%h want=0", rd_data); end
        peek(SEL_ENTRYLO0);
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_entrylo0 got=%h want=0", rd_data); end
        peek(SEL_ENTRYLO1);
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_entrylo1 got=%h want=0", rd_data); end
        peek(SEL_WIRED);
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_wired got=%h want=0", rd_data); end
        // Random write is ignored; the counter simply keeps decrementing
        mtc0(SEL_RANDOM, 32'd3);
        peek(SEL_RANDOM);
        checks++; if (rd_data !== 32'd14) begin errors++; $display("FAIL random_write_ignored got=%h want=%h", rd_data, 32'd14); end
    endtask

    task automatic test_write_wi();
        mtc0(SEL_ENTRYHI, 32'h2468_BF5A);
        mtc0(SEL_ENTRYLO0, 32'hFC00_1F47);
        mtc0(SEL_ENTRYLO1, 32'h0000_2F47);
        mtc0(SEL_INDEX, 32'h8000_0003);
        peek(SEL_INDEX);
        checks++; if (rd_data !== 32'h0000_0003) begin errors++; $display("FAIL index_p_readonly got=%h want=%h", rd_data, 32'h3); end
        peek(SEL_ENTRYHI);
        checks++; if (rd_data !== 32'h2468_A05A) begin errors++; $display("FAIL entryhi_mask got=%h want=%h", rd_data, 32'h2468_A05A); end
        peek(SEL_ENTRYLO0);
        checks++; if (rd_data !== 32'h0000_1F47) begin errors++; $display("FAIL entrylo0_mask got=%h want=%h", rd_data, 32'h1F47); end
        checks++; if (s_vpn2 !== 19'h12345 || s_asid !== 8'h5A || r_index !== 4'd3) begin errors++; $display("FAIL search_drive got vpn2=%h asid=%h ridx=%h want 12345 5a 3", s_vpn2, s_asid, r_index); end
        start_op(OP_TLBWI);
        checks++; if (we !== 1'b1 || w_index !== 4'd3 || w_g !== 1'b1) begin errors++; $display("FAIL wi_exec got we=%b idx=%h g=%b want 1 3 1", we, w_index, w_g); end
        checks++; if (w_pfn0 !== 20'h7D || w_c0 !== 3'd0 || w_d0 !== 1'b1 || w_v0 !== 1'b1) begin errors++; $display("FAIL wi_lo0 got pfn=%h c=%h d=%b v=%b want 7d 0 1 1", w_pfn0, w_c0, w_d0, w_v0); end
        checks++; if (w_pfn1 !== 20'hBD || w_vpn2 !== 19'h12345 || w_asid !== 8'h5A) begin errors++; $display("FAIL wi_hi_lo1 got pfn1=%h vpn2=%h asid=%h want bd 12345 5a", w_pfn1, w_vpn2, w_asid); end
        checks++; if (op_done !== 1'b0 || op_ready !== 1'b0) begin errors++; $display("FAIL wi_exec_ctrl got done=%b ready=%b want 0 0", op_done, op_ready); end
        tick();
        checks++; if (we !== 1'b0 || op_done !== 1'b1) begin errors++; $display("FAIL wi_done got we=%b done=%b want 0 1", we, op_done); end
        tick();
        checks++; if (op_done !== 1'b0 || op_ready !== 1'b1 || we !== 1'b0) begin errors++; $display("FAIL wi_idle got done=%b ready=%b we=%b want 0 1 0", op_done, op_ready, we); end
    endtask

    task automatic test_read_r();
        r_vpn2 = 19'h12345; r_asid = 8'h5A; r_g = 1'b1;
        r_pfn0 = 20'h7D; r_c0 = 3'd0; r_d0 = 1'b1; r_v0 = 1'b1;
        r_pfn1 = 20'hBD; r_c1 = 3'd0; r_d1 = 1'b1; r_v1 = 1'b1;
        mtc0(SEL_ENTRYHI, 32'h0);
        mtc0(SEL_ENTRYLO0, 32'h0);
        mtc0(SEL_ENTRYLO1, 32'h0);
        peek(SEL_ENTRYHI);
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL cleared_entryhi got=%h want=0", rd_data); end
        start_op(OP_TLBR);
        tick();
        tick();
        peek(SEL_ENTRYHI);
        checks++; if (rd_data !== 32'h2468_A05A) begin errors++; $display("FAIL tlbr_entryhi got=%h want=%h", rd_data, 32'h2468_A05A); end
        peek(SEL_ENTRYLO0);
        checks++; if (rd_data !== 32'h0000_1F47) begin errors++; $display("FAIL tlbr_entrylo0 got=%h want=%h", rd_data, 32'h1F47); end
        peek(SEL_ENTRYLO1);
        checks++; if (rd_data !== 32'h0000_2F47) begin errors++; $display("FAIL tlbr_entrylo1 got=%h want=%h", rd_data, 32'h2F47); end
        peek(SEL_INDEX);
        checks++; if (rd_data !== 32'h0000_0003) begin errors++; $display("FAIL tlbr_index_kept got=%h want=%h", rd_data, 32'h3); end
    endtask

    task automatic test_probe();
        s_found = 1'b1;
        s_index = 4'd9;
        start_op(OP_TLBP);
        checks++; if (op_done !== 1'b0 || we !== 1'b0) begin errors++; $display("FAIL probe_hit_exec got done=%b we=%b want 0 0", op_done, we); end
        tick();
        checks++; if (op_done !== 1'b1) begin errors++; $display("FAIL probe_hit_done got=%b want 1", op_done); end
        peek(SEL_INDEX);
        checks++; if (rd_data !== 32'h0000_0009) begin errors++; $display("FAIL probe_hit_index got=%h want=%h", rd_data, 32'h9); end
        tick();
        s_found = 1'b0;
        s_index = 4'd2;
        start_op(OP_TLBP);
        checks++; if (op_done !== 1'b0) begin errors++; $display("FAIL probe_miss_exec got done=%b want 0", op_done); end
        tick();
        checks++; if (op_done !== 1'b1) begin errors++; $display("FAIL probe_miss_done got=%b want 1", op_done); end
        peek(SEL_INDEX);
        checks++; if (rd_data !== 32'h8000_0009) begin errors++; $display("FAIL probe_miss_index got=%h want=%h", rd_data, 32'h8000_0009); end
        tick();
    endtask

    task automatic test_random();
        mtc0(SEL_ENTRYLO1, 32'h0000_2F46);
        mtc0(SEL_WIRED, 32'd14);
        peek(SEL_RANDOM);
        checks++; if (rd_data !== 32'd15) begin errors++; $display("FAIL random_seq0 got=%h want=%h", rd_data, 32'd15); end
        tick();
        peek(SEL_RANDOM);
        checks++; if (rd_data !== 32'd14) begin errors++; $display("FAIL random_seq1 got=%h want=%h", rd_data, 32'd14); end
        tick();
        peek(SEL_RANDOM);
        checks++; if (rd_data !== 32'd15) begin errors++; $display("FAIL random_seq2 got=%h want=%h", rd_data, 32'd15); end
        tick();
        peek(SEL_RANDOM);
        checks++; if (rd_data !== 32'd14) begin errors++; $display("FAIL random_seq3 got=%h want=%h", rd_data, 32'd14); end
        peek(SEL_WIRED);
        checks++; if (rd_data !== 32'd14) begin errors++; $display("FAIL wired_read got=%h want=%h", rd_data, 32'd14); end
        // Random is 14 now, so the EXEC cycle sees 15
        start_op(OP_TLBWR);
        peek(SEL_RANDOM);
        checks++; if (we !== 1'b1 || w_index !== 4'd15 || rd_data !== 32'd15) begin errors++; $display("FAIL tlbwr_exec got we=%b idx=%h random=%h want 1 f f", we, w_index, rd_data); end
        checks++; if (w_g !== 1'b0) begin errors++; $display("FAIL tlbwr_g_and got=%b want 0", w_g); end
        tick();
        checks++; if (we !== 1'b0 || op_done !== 1'b1) begin errors++; $display("FAIL tlbwr_done got we=%b done=%b want 0 1", we, op_done); end
        tick();
    endtask

    task automatic test_reset_exec();
        start_op(OP_TLBWI);
        rst = 1'b1;
        #1;
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL rst_exec_we got=%b want 0", we); end
        tick();
        rst = 1'b0;
        peek(SEL_RANDOM);
        checks++; if (op_ready !== 1'b1 || op_done !== 1'b0 || rd_data !== 32'd15) begin errors++; $display("FAIL rst_exec_after got ready=%b done=%b random=%h want 1 0 f", op_ready, op_done, rd_data); end
        peek(SEL_WIRED);
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL rst_exec_wired got=%h want=0", rd_data); end
        peek(SEL_INDEX);
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL rst_exec_index got=%h want=0", rd_data); end
        tick();
        checks++; if (op_done !== 1'b0 || we !== 1'b0) begin errors++; $display("FAIL rst_exec_nopulse got done=%b we=%b want 0 0", op_done, we); end
    endtask

    task automatic test_mtc0_busy();
        start_op(OP_TLBWI);
        mtc0(SEL_INDEX, 32'd5);
        mtc0(SEL_INDEX, 32'd5);
        peek(SEL_INDEX);
        checks++; if (rd_data !== 32'h0 || op_ready !== 1'b1) begin errors++; $display("FAIL busy_drop got index=%h ready=%b want 0 1", rd_data, op_ready); end
        op_valid   = 1'b1;
        op_code    = OP_TLBWI;
        mtc0_we    = 1'b1;
        mtc0_sel   = SEL_INDEX;
        mtc0_wdata = 32'd7;
        peek(SEL_INDEX);
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL no_bypass got=%h want=0", rd_data); end
        tick();
        op_valid = 1'b0;
        mtc0_we  = 1'b0;
        #1;
        checks++; if (we !== 1'b1 || w_index !== 4'd7) begin errors++; $display("FAIL coincident_write got we=%b idx=%h want 1 7", we, w_index); end
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_code = 2'd0;
        mtc0_we = 1'b0; mtc0_sel = 3'd0; mtc0_wdata = 32'h0;
        rd_sel = 3'd0; s_found = 1'b0; s_index = '0;
        r_vpn2 = '0; r_asid = '0; r_g = 1'b0;
        r_pfn0 = '0; r_c0 = '0; r_d0 = 1'b0; r_v0 = 1'b0;
        r_pfn1 = '0; r_c1 = '0; r_d1 = 1'b0; r_v1 = 1'b0;
        test_reset();
        test_write_wi();
        test_read_r();
        test_probe();
        test_random();
        test_reset_exec();
        test_mtc0_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tlb_op_unit.md
TLB_OP_UNIT -- requirements
Module: tlb_op_unit

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, number of TLB entries; IW = $clog2(TLBNUM).
REQ-002 SHALL have clk  in  1  clock; rst  in  1  reset, synchronous, active-high; all state SHALL be updated on posedge clk.
REQ-003 SHALL have op_valid  in  1  TLB instruction request.
REQ-004 SHALL have op_code  in  2  requested instruction: 0 TLBP, 1 TLBR, 2 TLBWI, 3 TLBWR.
REQ-005 SHALL have op_ready  out  1  unit idle, request acceptable.
REQ-006 SHALL have op_done  out  1  single-cycle completion pulse.
REQ-007 SHALL have mtc0_we  in  1, mtc0_sel  in  3 (0 Index, 1 EntryLo0, 2 EntryLo1, 3 EntryHi, 4 Wired, 5 Random), mtc0_wdata  in  32: register write port.
REQ-008 SHALL have rd_sel  in  3 (same encoding) and rd_data  out  32: combinational register read.
REQ-009 SHALL have s_vpn2  out  19, s_asid  out  8, s_found  in  1, s_index  in  IW: TLB search port.
REQ-010 SHALL have we  out  1, w_index  out  IW, and w_vpn2/w_asid/w_g/w_pfn0/w_c0/w_d0/w_v0/w_pfn1/w_c1/w_d1/w_v1  out  19/8/1/20/3/1/1/20/3/1/1: TLB write port.
REQ-011 SHALL have r_index  out  IW and r_vpn2/r_asid/r_g/r_pfn0/r_c0/r_d0/r_v0/r_pfn1/r_c1/r_d1/r_v1  in  (widths as REQ-010): TLB read port.

Function
REQ-012 Register layout SHALL be: EntryHi [31:13] VPN2, [7:0] ASID; EntryLo0/1 [25:6] PFN, [5:3] C, [2] D, [1] V, [0] G; Index [31] P, [IW-1:0] index; Wired and Random [IW-1:0]. Unlisted bits SHALL read 0.
REQ-013 The FSM SHALL have states IDLE, EXEC, DONE; op_ready SHALL be 1 only in IDLE.
REQ-014 IDLE->EXEC SHALL occur when op_valid=1; op_code SHALL be latched on that edge.
REQ-015 EXEC->DONE SHALL be unconditional. DONE->IDLE SHALL be unconditional. op_done SHALL be 1 in DONE only, giving 2-cycle latency from acceptance.
REQ-016 s_vpn2/s_asid SHALL continuously drive EntryHi.VPN2/ASID. r_index SHALL continuously drive Index.index.
REQ-017 TLBP in EXEC: if s_found=1, SHALL set Index.P=0 and Index.index=s_index; otherwise SHALL set P=1 and leave index unchanged.
REQ-018 TLBR in EXEC: SHALL load EntryHi.VPN2/ASID from r_vpn2/r_asid. SHALL load EntryLo0 from {r_pfn0,r_c0,r_d0,r_v0,r_g} and EntryLo1 from {r_pfn1,r_c1,r_d1,r_v1,r_g}.
REQ-019 TLBWI/TLBWR in EXEC: we SHALL be 1 for exactly that cycle. w_index SHALL be Index.index (TLBWI) or the current Random (TLBWR). w_g SHALL be EntryLo0.G AND EntryLo1.G. Remaining w_* fields SHALL come from EntryHi/EntryLo0/EntryLo1.
REQ-020 we SHALL be 0 in every other cycle.
REQ-021 Random SHALL decrement every cycle. When Random equals Wired, or is below it, the next value SHALL be TLBNUM-1 (wrap).
REQ-022 An mtc0 write to Wired SHALL set Wired=wdata[IW-1:0] and set Random=TLBNUM-1 on the same edge.
REQ-023 mtc0 writes to Random SHALL be ignored.
REQ-024 mtc0 writes to Index SHALL update only the index field; P is software read-only.
REQ-025 mtc0 writes SHALL take effect only when op_ready=1 and SHALL be dropped otherwise.
REQ-026 If mtc0_we and an op acceptance coincide, the mtc0 write SHALL land on that edge and the op SHALL see the new value in EXEC.
REQ-027 rd_data SHALL reflect the register value after the last edge, with no bypass of same-cycle writes.

Reset
REQ-028 rst SHALL force the FSM to IDLE, aborting any op with no we pulse, and SHALL clear op_done=0 and we=0.
REQ-029 rst SHALL clear EntryHi, EntryLo0, EntryLo1, Index (P=0) and Wired to 0, and SHALL set Random to TLBNUM-1.
REQ-030 rst SHALL take priority over all other writes.

Structure
REQ-031 Package tlb_pkg SHALL hold the op_code and mtc0_sel encodings, the field widths (VPN2 19, ASID 8, PFN 20, C 3) and the EntryLo/EntryHi bit positions.
REQ-032 The Random/Wired logic SHALL be one sub-module, tlb_random (inputs: wired write strobe and value; output: random).
REQ-033 The FSM, CP0 registers and TLB port drive SHALL be in tlb_op_unit.

Verification
REQ-034 Write then read back: EntryHi VPN2=0x12345, ASID=0x5A; EntryLo0=0x0000_1F47 and EntryLo1=0x0000_2F47 (both G=1); Index=3; TLBWI. Expected: we=1 for one cycle with w_index=3, w_g=1, w_pfn0=0x7D. Then clear the registers and run TLBR. Expected: all registers restored.
REQ-035 Probe hit and miss: s_found=1 with s_index=9 -> Index=0x0000_0009. Then s_found=0 -> Index=0x8000_0009. op_done SHALL pulse exactly 2 cycles after acceptance in both cases.
REQ-036 Random sequence: write Wired=14 with TLBNUM=16. Expected Random sequence 15, 14, 15, 14, … and TLBWR w_index equal to Random in the EXEC cycle.
REQ-037 Reset in EXEC of a TLBWI: assert rst. Expected: we=0, op_done never pulses, op_ready=1 the next cycle, Random=15.
REQ-038 mtc0 while busy: mtc0 write Index=5 during DONE -> Index unchanged; mtc0 write coincident with acceptance -> the op uses the new value.
